store_data_queue: RTL and testbench

- Circular, program-ordered queue holding in-flight stores for the LSU.
- Dispatch allocates entries in order and receives an SDQ marker; the load queue tags each load with this marker.
- Execution fills address and data independently; retirement marks entries committed.
- Committed, complete entries drain in order to the data memory port over a valid/ready handshake. The block exports its head marker so load-ordering logic can tell which older stores have drained.

---
 rtl/store_data_queue_pkg.sv | 38 +++
 rtl/store_data_queue_if.sv | 42 ++++
 rtl/store_data_queue_byte_align.sv | 37 +++
 rtl/store_data_queue.sv | 107 ++++++++++
 tb/tb_store_data_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_data_queue_pkg.sv
// Shared definitions for the store data queue and the load queue.
//   SDQ_ENTRIES  : number of queue entries (power of two, >= 2)
//   IDX_W        : entry index width; markers are IDX_W+1 bits wide
//   mem_size_e   : access size encoding (2'b11 is treated as a word)
//   sdq_entry_t  : one in-flight store
//   marker_older : wrap-aware "a is older than b" for queue markers
package store_data_queue_pkg;

    localparam int SDQ_ENTRIES = 8;
    localparam int IDX_W       = $clog2(SDQ_ENTRIES);

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    typedef struct packed {
        logic        valid;
        logic        committed;
        logic        addr_valid;
        logic        data_valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } sdq_entry_t;

    // Same wrap bit: plain index order. Different wrap bits: the pointer
    // that has not wrapped yet sits at the higher index and is older.
    function automatic logic marker_older(input logic [IDX_W:0] a,
                                          input logic [IDX_W:0] b);
        if (a[IDX_W] == b[IDX_W]) begin
            return a[IDX_W-1:0] < b[IDX_W-1:0];
        end
        return a[IDX_W-1:0] > b[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/store_data_queue_if.sv
// Bus between the LSU and the store data queue.
//   dispatch : disp_vld -> disp_sdq_marker, disp_full
//   execute  : exec_addr_vld/idx/addr/size, exec_data_vld/idx/data
//   retire   : commit_vld
//   drain    : mem_req_vld/addr/data/be -> mem_req_rdy
//   ordering : sdq_head_marker
// The slave modport is the queue itself; master is the LSU/memory side.
interface store_data_queue_if;

    logic                                disp_vld;
    logic [store_data_queue_pkg::IDX_W:0] disp_sdq_marker;
    logic                                disp_full;
    logic                                exec_addr_vld;
    logic [store_data_queue_pkg::IDX_W-1:0] exec_addr_idx;
    logic [31:0]                         exec_addr;
    logic [1:0]                          exec_size;
    logic                                exec_data_vld;
    logic [store_data_queue_pkg::IDX_W-1:0] exec_data_idx;
    logic [31:0]                         exec_data;
    logic                                commit_vld;
    logic                                mem_req_vld;
    logic [31:0]                         mem_req_addr;
    logic [31:0]                         mem_req_data;
    logic [3:0]                          mem_req_be;
    logic                                mem_req_rdy;
    logic [store_data_queue_pkg::IDX_W:0] sdq_head_marker;

    modport master (
        output disp_vld, exec_addr_vld, exec_addr_idx, exec_addr, exec_size,
               exec_data_vld, exec_data_idx, exec_data, commit_vld, mem_req_rdy,
        input  disp_sdq_marker, disp_full, mem_req_vld, mem_req_addr,
               mem_req_data, mem_req_be, sdq_head_marker
    );

    modport slave (
        input  disp_vld, exec_addr_vld, exec_addr_idx, exec_addr, exec_size,
               exec_data_vld, exec_data_idx, exec_data, commit_vld, mem_req_rdy,
        output disp_sdq_marker, disp_full, mem_req_vld, mem_req_addr,
               mem_req_data, mem_req_be, sdq_head_marker
    );

endinterface

// File: rtl/store_data_queue_byte_align.sv
// Combinational byte-lane placement for a naturally aligned store.
//   addr_lo   : address bits [1:0]
//   size      : access size (mem_size_e encoding, 2'b11 behaves as word)
//   data      : right-justified store data
//   be        : byte enables
//   lane_data : data shifted into its byte lanes, unused lanes zero
module store_byte_align
    import store_data_queue_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] lane_data
);

    // Word (and the unused 2'b11 code) pass straight through.
    always_comb begin
        be        = 4'b1111;
        lane_data = data;
        case (size)
            BYTE: begin
                be        = 4'b0001 << addr_lo;
                lane_data = {24'h0, data[7:0]} << {addr_lo, 3'b000};
            end
            HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                lane_data = {16'h0, data[15:0]} << {addr_lo[1], 4'b0000};
            end
            default: begin
                be        = 4'b1111;
                lane_data = data;
            end
        endcase
    end

endmodule

// File: rtl/store_data_queue.sv
// Circular, program-ordered store data queue.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   sdq   : LSU bus (dispatch, execute writes, commit, memory drain,
//           head marker)
// head = oldest live entry, cmt = oldest uncommitted, tail = next free.
// All pointers carry a wrap bit so full and empty are distinguishable.
module store_data_queue
    import store_data_queue_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    store_data_queue_if.slave sdq
);

    sdq_entry_t     entries [SDQ_ENTRIES];
    sdq_entry_t     head_entry;
    logic [IDX_W:0] head;
    logic [IDX_W:0] cmt;
    logic [IDX_W:0] tail;
    logic           full;
    logic           alloc;
    logic           commit_ok;
    logic           head_ready;
    logic           drain;
    logic [3:0]     head_be;
    logic [31:0]    head_lane_data;

    // Full uses registered pointers only, so a same-cycle drain never
    // opens a slot for dispatch.
    assign full       = (head[IDX_W-1:0] == tail[IDX_W-1:0]) &&
                        (head[IDX_W] != tail[IDX_W]);
    assign alloc      = sdq.disp_vld && !full;
    assign commit_ok  = sdq.commit_vld && (cmt != tail);
    assign head_entry = entries[head[IDX_W-1:0]];
    assign head_ready = head_entry.valid && head_entry.committed &&
                        head_entry.addr_valid && head_entry.data_valid;
    assign drain      = head_ready && sdq.mem_req_rdy;

    store_byte_align u_align (
        .addr_lo   (head_entry.addr[1:0]),
        .size      (head_entry.size),
        .data      (head_entry.data),
        .be        (head_be),
        .lane_data (head_lane_data)
    );

    // Request fields are zeroed when idle so reset and empty look alike.
    assign sdq.disp_full       = full;
    assign sdq.disp_sdq_marker = full ? '0 : tail;
    assign sdq.mem_req_vld     = head_ready;
    assign sdq.mem_req_addr    = head_ready ? {head_entry.addr[31:2], 2'b00} : 32'h0;
    assign sdq.mem_req_data    = head_ready ? head_lane_data : 32'h0;
    assign sdq.mem_req_be      = head_ready ? head_be : 4'h0;
    assign sdq.sdq_head_marker = head;

    // Pointer advance: each pointer moves at most one step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            cmt  <= '0;
            tail <= '0;
        end else begin
            if (alloc) begin
                tail <= tail + 1'b1;
            end
            if (commit_ok) begin
                cmt <= cmt + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
        end
    end

    // Entry updates. Exec writes to free entries are dropped. Allocation
    // is applied last; its slot is free (not full), so the other updates
    // never target it with a live entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SDQ_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (sdq.exec_addr_vld && entries[sdq.exec_addr_idx].valid) begin
                entries[sdq.exec_addr_idx].addr       <= sdq.exec_addr;
                entries[sdq.exec_addr_idx].size       <= sdq.exec_size;
                entries[sdq.exec_addr_idx].addr_valid <= 1'b1;
            end
            if (sdq.exec_data_vld && entries[sdq.exec_data_idx].valid) begin
                entries[sdq.exec_data_idx].data       <= sdq.exec_data;
                entries[sdq.exec_data_idx].data_valid <= 1'b1;
            end
            if (commit_ok) begin
                entries[cmt[IDX_W-1:0]].committed <= 1'b1;
            end
            if (drain) begin
                entries[head[IDX_W-1:0]].valid <= 1'b0;
            end
            if (alloc) begin
                entries[tail[IDX_W-1:0]]       <= '0;
                entries[tail[IDX_W-1:0]].valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_data_queue.sv
// Self-checking bench for store_data_queue. A queue of slot numbers in
// allocation order plus per-slot address/size/data arrays form the
// reference; expected lanes and enables are computed arithmetically.
module tb_store_data_queue;
    import store_data_queue_pkg::*;

    localparam int MW = IDX_W + 1;
    localparam int MOD = 1 << MW;

    logic clk;
    logic rst_n;

    store_data_queue_if sdq_bus ();

    store_data_queue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sdq   (sdq_bus)
    );

    int checks;
    int errors;

    logic [31:0] m_addr [SDQ_ENTRIES];
    logic [31:0] m_data [SDQ_ENTRIES];
    logic [1:0]  m_size [SDQ_ENTRIES];
    int          exp_q[$];
    int          alloc_count;
    int          drain_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] s);
        int lane;
        lane = int'(a[1:0]);
        if (s == 2'b00) return 4'(1 << lane);
        if (s == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a, input logic [1:0] s,
                                             input logic [31:0] d);
        logic [31:0] b;
        int lane;
        lane = int'(a[1:0]);
        b = {24'h0, d[7:0]};
        if (s == 2'b00) return b << (8 * lane);
        if (s == 2'b01) return a[1] ? {d[15:0], 16'h0} : {16'h0, d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] rand_aligned(input logic [1:0] s);
        logic [31:0] a;
        a = $urandom;
        if (s == 2'b01) a[0] = 1'b0;
        if (s[1]) a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sdq_bus.disp_vld      = 1'b0;
        sdq_bus.exec_addr_vld = 1'b0;
        sdq_bus.exec_addr_idx = '0;
        sdq_bus.exec_addr     = 32'h0;
        sdq_bus.exec_size     = 2'b00;
        sdq_bus.exec_data_vld = 1'b0;
        sdq_bus.exec_data_idx = '0;
        sdq_bus.exec_data     = 32'h0;
        sdq_bus.commit_vld    = 1'b0;
        sdq_bus.mem_req_rdy   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        alloc_count = 0;
        drain_count = 0;
        tick();
    endtask

    // Writes address, size and data to one slot, optionally committing.
    task automatic write_store(input int slot, input logic do_commit);
        sdq_bus.exec_addr_vld = 1'b1;
        sdq_bus.exec_addr_idx = IDX_W'(slot);
        sdq_bus.exec_addr     = m_addr[slot];
        sdq_bus.exec_size     = m_size[slot];
        sdq_bus.exec_data_vld = 1'b1;
        sdq_bus.exec_data_idx = IDX_W'(slot);
        sdq_bus.exec_data     = m_data[slot];
        sdq_bus.commit_vld    = do_commit;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        checks++; if (sdq_bus.disp_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %0h, expected 0", sdq_bus.disp_full); end
        checks++; if (sdq_bus.disp_sdq_marker !== MW'(0)) begin errors++; $display("[TB] FAIL reset_marker: got %0h, expected 0", sdq_bus.disp_sdq_marker); end
        checks++; if (sdq_bus.mem_req_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %0h, expected 0", sdq_bus.mem_req_vld); end
        checks++; if (sdq_bus.mem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %0h, expected 0", sdq_bus.mem_req_addr); end
        checks++; if (sdq_bus.mem_req_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %0h, expected 0", sdq_bus.mem_req_data); end
        checks++; if (sdq_bus.mem_req_be !== 4'h0) begin errors++; $display("[TB] FAIL reset_be: got %0h, expected 0", sdq_bus.mem_req_be); end
        checks++; if (sdq_bus.sdq_head_marker !== MW'(0)) begin errors++; $display("[TB] FAIL reset_head: got %0h, expected 0", sdq_bus.sdq_head_marker); end
        do_reset();
    endtask

    // Eight dispatches fill the queue; a ninth is dropped.
    task automatic test_fill();
        for (int i = 0; i < SDQ_ENTRIES; i++) begin
            checks++; if (sdq_bus.disp_sdq_marker !== MW'(i)) begin errors++; $display("[TB] FAIL fill_marker%0d: got %0h, expected %0h", i, sdq_bus.disp_sdq_marker, i); end
            checks++; if (sdq_bus.disp_full !== 1'b0) begin errors++; $display("[TB] FAIL fill_notfull%0d: got %0h, expected 0", i, sdq_bus.disp_full); end
            sdq_bus.disp_vld = 1'b1;
            tick();
            exp_q.push_back(i);
            alloc_count++;
        end
        checks++; if (sdq_bus.disp_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %0h, expected 1", sdq_bus.disp_full); end
        checks++; if (sdq_bus.disp_sdq_marker !== MW'(0)) begin errors++; $display("[TB] FAIL fill_full_marker: got %0h, expected 0", sdq_bus.disp_sdq_marker); end
        tick();
        sdq_bus.disp_vld = 1'b0;
        checks++; if (sdq_bus.disp_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_drop_full: got %0h, expected 1", sdq_bus.disp_full); end
    endtask

    // Continues from the full queue: three rounds of 8 stores, with
    // addresses and data to different entries in the same cycle as a
    // commit, then a randomly throttled drain checked in order.
    task automatic test_wrap();
        int budget;
        int s;
        logic rdy;
        for (int r = 0; r < 3; r++) begin
            if (r > 0) begin
                for (int i = 0; i < SDQ_ENTRIES; i++) begin
                    checks++; if (sdq_bus.disp_sdq_marker !== MW'(alloc_count % MOD)) begin errors++; $display("[TB] FAIL wrap_marker: got %0h, expected %0h", sdq_bus.disp_sdq_marker, alloc_count % MOD); end
                    sdq_bus.disp_vld = 1'b1;
                    tick();
                    exp_q.push_back(alloc_count % SDQ_ENTRIES);
                    alloc_count++;
                end
                sdq_bus.disp_vld = 1'b0;
            end
            for (int k = 0; k < SDQ_ENTRIES; k++) begin
                m_size[k] = 2'($urandom_range(0, 3));
                m_addr[k] = rand_aligned(m_size[k]);
                m_data[k] = $urandom;
            end
            for (int k = 0; k < SDQ_ENTRIES; k++) begin
                sdq_bus.exec_addr_vld = 1'b1;
                sdq_bus.exec_addr_idx = IDX_W'(k);
                sdq_bus.exec_addr     = m_addr[k];
                sdq_bus.exec_size     = m_size[k];
                sdq_bus.exec_data_vld = 1'b1;
                sdq_bus.exec_data_idx = IDX_W'(SDQ_ENTRIES - 1 - k);
                sdq_bus.exec_data     = m_data[SDQ_ENTRIES - 1 - k];
                sdq_bus.commit_vld    = 1'b1;
                tick();
            end
            idle();
            budget = 200;
            while (exp_q.size() > 0 && budget > 0) begin
                rdy = ($urandom_range(0, 3) != 0);
                sdq_bus.mem_req_rdy = rdy;
                if (sdq_bus.mem_req_vld && rdy) begin
                    s = exp_q.pop_front();
                    checks++; if (sdq_bus.mem_req_addr !== {m_addr[s][31:2], 2'b00}) begin errors++; $display("[TB] FAIL wrap_addr: got %0h, expected %0h", sdq_bus.mem_req_addr, {m_addr[s][31:2], 2'b00}); end
                    checks++; if (sdq_bus.mem_req_be !== exp_be(m_addr[s], m_size[s])) begin errors++; $display("[TB] FAIL wrap_be: got %0h, expected %0h", sdq_bus.mem_req_be, exp_be(m_addr[s], m_size[s])); end
                    checks++; if (sdq_bus.mem_req_data !== exp_data(m_addr[s], m_size[s], m_data[s])) begin errors++; $display("[TB] FAIL wrap_data: got %0h, expected %0h", sdq_bus.mem_req_data, exp_data(m_addr[s], m_size[s], m_data[s])); end
                    drain_count++;
                end
                tick();
                budget--;
                checks++; if (sdq_bus.sdq_head_marker !== MW'(drain_count % MOD)) begin errors++; $display("[TB] FAIL wrap_head: got %0h, expected %0h", sdq_bus.sdq_head_marker, drain_count % MOD); end
            end
            sdq_bus.mem_req_rdy = 1'b0;
            checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL wrap_drain_timeout: got %0d left, expected 0", exp_q.size()); end
        end
    endtask

    // Data first, address one cycle later, then commit.
    task automatic test_basic();
        do_reset();
        checks++; if (sdq_bus.disp_sdq_marker !== MW'(0)) begin errors++; $display("[TB] FAIL basic_marker: got %0h, expected 0", sdq_bus.disp_sdq_marker); end
        sdq_bus.disp_vld = 1'b1;
        tick();
        idle();
        sdq_bus.exec_data_vld = 1'b1;
        sdq_bus.exec_data_idx = '0;
        sdq_bus.exec_data     = 32'hDEADBEEF;
        tick();
        idle();
        sdq_bus.exec_addr_vld = 1'b1;
        sdq_bus.exec_addr_idx = '0;
        sdq_bus.exec_addr     = 32'h1000;
        sdq_bus.exec_size     = 2'b10;
        tick();
        idle();
        checks++; if (sdq_bus.mem_req_vld !== 1'b0) begin errors++; $display("[TB] FAIL basic_uncommitted_vld: got %0h, expected 0", sdq_bus.mem_req_vld); end
        sdq_bus.commit_vld = 1'b1;
        tick();
        idle();
        checks++; if (sdq_bus.mem_req_vld !== 1'b1) begin errors++; $display("[TB] FAIL basic_vld: got %0h, expected 1", sdq_bus.mem_req_vld); end
        checks++; if (sdq_bus.mem_req_addr !== 32'h1000) begin errors++; $display("[TB] FAIL basic_addr: got %0h, expected 1000", sdq_bus.mem_req_addr); end
        checks++; if (sdq_bus.mem_req_be !== 4'hF) begin errors++; $display("[TB] FAIL basic_be: got %0h, expected f", sdq_bus.mem_req_be); end
        checks++; if (sdq_bus.mem_req_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL basic_data: got %0h, expected deadbeef", sdq_bus.mem_req_data); end
        sdq_bus.mem_req_rdy = 1'b1;
        tick();
        idle();
        checks++; if (sdq_bus.sdq_head_marker !== MW'(1)) begin errors++; $display("[TB] FAIL basic_head: got %0h, expected 1", sdq_bus.sdq_head_marker); end
        checks++; if (sdq_bus.mem_req_vld !== 1'b0) begin errors++; $display("[TB] FAIL basic_vld_after: got %0h, expected 0", sdq_bus.mem_req_vld); end
    endtask

    // Byte, half and size-3 (word) stores at slots 1..3.
    task automatic test_align();
        m_addr[1] = 32'h2003; m_size[1] = 2'b00; m_data[1] = 32'h000000AB;
        m_addr[2] = 32'h2002; m_size[2] = 2'b01; m_data[2] = 32'h00001234;
        m_addr[3] = 32'h3000; m_size[3] = 2'b11; m_data[3] = 32'hCAFEF00D;
        for (int i = 1; i <= 3; i++) begin
            checks++; if (sdq_bus.disp_sdq_marker !== MW'(i)) begin errors++; $display("[TB] FAIL align_marker: got %0h, expected %0h", sdq_bus.disp_sdq_marker, i); end
            sdq_bus.disp_vld = 1'b1;
            tick();
        end
        idle();
        for (int i = 1; i <= 3; i++) write_store(i, 1'b1);
        checks++; if (sdq_bus.mem_req_be !== 4'b1000) begin errors++; $display("[TB] FAIL align_byte_be: got %0h, expected 8", sdq_bus.mem_req_be); end
        checks++; if (sdq_bus.mem_req_data !== 32'hAB000000) begin errors++; $display("[TB] FAIL align_byte_data: got %0h, expected ab000000", sdq_bus.mem_req_data); end
        checks++; if (sdq_bus.mem_req_addr !== 32'h2000) begin errors++; $display("[TB] FAIL align_byte_addr: got %0h, expected 2000", sdq_bus.mem_req_addr); end
        sdq_bus.mem_req_rdy = 1'b1;
        tick();
        checks++; if (sdq_bus.mem_req_be !== 4'b1100) begin errors++; $display("[TB] FAIL align_half_be: got %0h, expected c", sdq_bus.mem_req_be); end
        checks++; if (sdq_bus.mem_req_data !== 32'h12340000) begin errors++; $display("[TB] FAIL align_half_data: got %0h, expected 12340000", sdq_bus.mem_req_data); end
        checks++; if (sdq_bus.mem_req_addr !== 32'h2000) begin errors++; $display("[TB] FAIL align_half_addr: got %0h, expected 2000", sdq_bus.mem_req_addr); end
        tick();
        checks++; if (sdq_bus.mem_req_be !== 4'hF) begin errors++; $display("[TB] FAIL align_word_be: got %0h, expected f", sdq_bus.mem_req_be); end
        checks++; if (sdq_bus.mem_req_data !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL align_word_data: got %0h, expected cafef00d", sdq_bus.mem_req_data); end
        tick();
        idle();
        checks++; if (sdq_bus.sdq_head_marker !== MW'(4)) begin errors++; $display("[TB] FAIL align_head: got %0h, expected 4", sdq_bus.sdq_head_marker); end
    endtask

    // Two stores at slots 4 and 5; hold rdy low, then release for one cycle.
    task automatic test_stall();
        m_size[4] = 2'b10; m_addr[4] = rand_aligned(2'b10); m_data[4] = $urandom;
        m_size[5] = 2'b00; m_addr[5] = rand_aligned(2'b00); m_data[5] = $urandom;
        sdq_bus.disp_vld = 1'b1;
        tick();
        tick();
        idle();
        write_store(4, 1'b1);
        write_store(5, 1'b1);
        for (int c = 0; c < 5; c++) begin
            checks++; if (sdq_bus.mem_req_vld !== 1'b1) begin errors++; $display("[TB] FAIL stall_vld%0d: got %0h, expected 1", c, sdq_bus.mem_req_vld); end
            checks++; if (sdq_bus.mem_req_addr !== {m_addr[4][31:2], 2'b00}) begin errors++; $display("[TB] FAIL stall_addr%0d: got %0h, expected %0h", c, sdq_bus.mem_req_addr, {m_addr[4][31:2], 2'b00}); end
            checks++; if (sdq_bus.mem_req_data !== m_data[4]) begin errors++; $display("[TB] FAIL stall_data%0d: got %0h, expected %0h", c, sdq_bus.mem_req_data, m_data[4]); end
            checks++; if (sdq_bus.sdq_head_marker !== MW'(4)) begin errors++; $display("[TB] FAIL stall_head%0d: got %0h, expected 4", c, sdq_bus.sdq_head_marker); end
            tick();
        end
        sdq_bus.mem_req_rdy = 1'b1;
        tick();
        sdq_bus.mem_req_rdy = 1'b0;
        checks++; if (sdq_bus.sdq_head_marker !== MW'(5)) begin errors++; $display("[TB] FAIL stall_one_drain: got %0h, expected 5", sdq_bus.sdq_head_marker); end
        checks++; if (sdq_bus.mem_req_be !== exp_be(m_addr[5], 2'b00)) begin errors++; $display("[TB] FAIL stall_next_be: got %0h, expected %0h", sdq_bus.mem_req_be, exp_be(m_addr[5], 2'b00)); end
        checks++; if (sdq_bus.mem_req_data !== exp_data(m_addr[5], 2'b00, m_data[5])) begin errors++; $display("[TB] FAIL stall_next_data: got %0h, expected %0h", sdq_bus.mem_req_data, exp_data(m_addr[5], 2'b00, m_data[5])); end
        tick();
        checks++; if (sdq_bus.sdq_head_marker !== MW'(5)) begin errors++; $display("[TB] FAIL stall_hold_head: got %0h, expected 5", sdq_bus.sdq_head_marker); end
    endtask

    // Queue is stalled on slot 5; reset lands between clock edges.
    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sdq_bus.mem_req_vld !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_vld: got %0h, expected 0", sdq_bus.mem_req_vld); end
        checks++; if (sdq_bus.sdq_head_marker !== MW'(0)) begin errors++; $display("[TB] FAIL rstmid_head: got %0h, expected 0", sdq_bus.sdq_head_marker); end
        checks++; if (sdq_bus.disp_sdq_marker !== MW'(0)) begin errors++; $display("[TB] FAIL rstmid_tail: got %0h, expected 0", sdq_bus.disp_sdq_marker); end
        checks++; if (sdq_bus.mem_req_be !== 4'h0) begin errors++; $display("[TB] FAIL rstmid_be: got %0h, expected 0", sdq_bus.mem_req_be); end
        do_reset();
    endtask

    // Commits on an empty queue must not move the commit pointer.
    task automatic test_commit_empty();
        sdq_bus.commit_vld = 1'b1;
        tick();
        tick();
        idle();
        checks++; if (sdq_bus.disp_sdq_marker !== MW'(0)) begin errors++; $display("[TB] FAIL cempty_marker: got %0h, expected 0", sdq_bus.disp_sdq_marker); end
        m_addr[0] = 32'h4000; m_size[0] = 2'b10; m_data[0] = 32'h11223344;
        sdq_bus.disp_vld = 1'b1;
        tick();
        idle();
        write_store(0, 1'b0);
        tick();
        checks++; if (sdq_bus.mem_req_vld !== 1'b0) begin errors++; $display("[TB] FAIL cempty_no_commit: got %0h, expected 0", sdq_bus.mem_req_vld); end
        sdq_bus.commit_vld = 1'b1;
        tick();
        idle();
        checks++; if (sdq_bus.mem_req_vld !== 1'b1) begin errors++; $display("[TB] FAIL cempty_vld: got %0h, expected 1", sdq_bus.mem_req_vld); end
        checks++; if (sdq_bus.mem_req_data !== 32'h11223344) begin errors++; $display("[TB] FAIL cempty_data: got %0h, expected 11223344", sdq_bus.mem_req_data); end
        sdq_bus.mem_req_rdy = 1'b1;
        tick();
        idle();
        checks++; if (sdq_bus.sdq_head_marker !== MW'(1)) begin errors++; $display("[TB] FAIL cempty_head: got %0h, expected 1", sdq_bus.sdq_head_marker); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        alloc_count = 0;
        drain_count = 0;
        rst_n = 1'b1;
        idle();
        #2;
        test_reset();
        test_fill();
        test_wrap();
        test_basic();
        test_align();
        test_stall();
        test_reset_mid();
        test_commit_empty();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
